// File: rtl/apple1_mem_pkg.sv
// Shared types for the Apple-1 memory arbiter: eraser states, read-select codes
// and the RAM port request bundle.
package apple1_mem_pkg;
  localparam int CPU_AW = 16;

  typedef enum logic [1:0] {ER_IDLE, ER_ERASE, ER_DONE} erase_state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_BASIC, SEL_WOZ} bus_sel_t;

  typedef struct packed {
    logic [CPU_AW-1:0] addr;
    logic [7:0]        din;
    logic              we;
    logic              ena;
  } mem_req_t;

  // One bit wider than the CPU bus so a region ending at 16'hFFFF+1 does not wrap.
  function automatic logic in_region(input logic [CPU_AW:0] a,
                                     input logic [CPU_AW:0] base,
                                     input logic [CPU_AW:0] size);
    return (a >= base) && (a < base + size);
  endfunction
endpackage

// File: rtl/apple1_mem_arbiter_if.sv
// 6502-side bus between the CPU core and the memory arbiter.
interface apple1_mem_arbiter_if;
  import apple1_mem_pkg::*;

  logic              cpu_clken;
  logic [CPU_AW-1:0] cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [7:0]        bus_dout;
  logic              cpu_hold;

  modport master (output cpu_clken, cpu_addr, cpu_dout, cpu_rd, cpu_wr,
                  input  bus_dout, cpu_hold);
  modport slave  (input  cpu_clken, cpu_addr, cpu_dout, cpu_rd, cpu_wr,
                  output bus_dout, cpu_hold);
endinterface

// File: rtl/apple1_ram_eraser.sv
// RAM eraser: walks 0..RAM_TOP-1 one write per clock, pausing whenever the
// downloader takes the RAM port.
module apple1_ram_eraser
  import apple1_mem_pkg::*;
#(
  parameter logic [CPU_AW-1:0] RAM_TOP        = 16'hC000,
  parameter bit                ERASE_ON_RESET = 1'b1
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              erase_req,
  input  logic              stall,
  output logic [CPU_AW-1:0] addr,
  output logic              we,
  output logic              busy
);
  localparam logic [CPU_AW-1:0] LAST = RAM_TOP - 16'd1;

  erase_state_t      state_q, state_d;
  logic [CPU_AW-1:0] addr_q, addr_d;
  logic              boot_q;
  logic              busy_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ER_IDLE:  if (erase_req || boot_q) state_d = ER_ERASE;
      ER_ERASE: if (!stall) begin
        if (addr_q == LAST) begin
          state_d = ER_DONE;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + 16'd1;
        end
      end
      ER_DONE:  state_d = ER_IDLE;
      default:  state_d = ER_IDLE;
    endcase
  end

  // boot_q turns the first clock after reset release into an implicit erase request.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ER_IDLE;
      addr_q  <= '0;
      boot_q  <= ERASE_ON_RESET;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      boot_q  <= 1'b0;
      busy_q  <= (state_d == ER_ERASE);
    end
  end

  assign addr = addr_q;
  assign busy = busy_q;
  assign we   = busy_q & ~stall;
endmodule

// File: rtl/apple1_mem_arbiter.sv
// Apple-1 memory arbiter: downloader > eraser > CPU on the RAM port, plus the
// CPU address decode, ROM write-protect and registered read-select.
module apple1_mem_arbiter
  import apple1_mem_pkg::*;
#(
  parameter logic [CPU_AW-1:0] RAM_TOP        = 16'hC000,
  parameter logic [CPU_AW-1:0] BASIC_BASE     = 16'hE000,
  parameter int                BASIC_SIZE     = 4096,
  parameter logic [CPU_AW-1:0] WOZ_BASE       = 16'hFF00,
  parameter int                WOZ_SIZE       = 256,
  parameter logic [7:0]        FILL_VALUE     = 8'h00,
  parameter logic [7:0]        UNMAPPED_VALUE = 8'h00,
  parameter bit                ERASE_ON_RESET = 1'b1,
  parameter int                DL_AW          = 25
) (
  input  logic                sys_clock,
  input  logic                reset_n,
  apple1_mem_arbiter_if.slave cpu,
  input  logic                dl_active,
  input  logic                dl_wr,
  input  logic [DL_AW-1:0]    dl_addr,
  input  logic [7:0]          dl_data,
  input  logic                erase_req,
  output logic                erase_busy,
  output logic                dl_range_err,
  output logic [CPU_AW-1:0]   mem_addr,
  output logic [7:0]          mem_din,
  output logic                mem_we,
  output logic                mem_ena,
  input  logic [7:0]          ram_dout,
  input  logic [7:0]          basic_dout,
  input  logic [7:0]          woz_dout
);
  localparam logic [CPU_AW:0] BASIC_SZ = BASIC_SIZE[CPU_AW:0];
  localparam logic [CPU_AW:0] WOZ_SZ   = WOZ_SIZE[CPU_AW:0];

  logic [CPU_AW:0]   a17;
  logic              ram_cs, basic_cs, woz_cs;
  bus_sel_t          dec_sel, sel_q;
  logic              dl_go, dl_in_ram, dl_active_q;
  logic [CPU_AW-1:0] er_addr;
  logic              er_we, er_busy;
  mem_req_t          mem_req;

  // ---- decode ----
  assign a17      = {1'b0, cpu.cpu_addr};
  assign ram_cs   = a17 < {1'b0, RAM_TOP};
  assign basic_cs = in_region(a17, {1'b0, BASIC_BASE}, BASIC_SZ);
  assign woz_cs   = in_region(a17, {1'b0, WOZ_BASE}, WOZ_SZ);

  always_comb begin
    dec_sel = SEL_NONE;
    if (woz_cs)        dec_sel = SEL_WOZ;
    else if (basic_cs) dec_sel = SEL_BASIC;
    else if (ram_cs)   dec_sel = SEL_RAM;
  end

  // ---- eraser ----
  assign dl_go     = dl_active & dl_wr;
  assign dl_in_ram = dl_addr < DL_AW'(RAM_TOP);

  apple1_ram_eraser #(
    .RAM_TOP        (RAM_TOP),
    .ERASE_ON_RESET (ERASE_ON_RESET)
  ) u_eraser (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .erase_req (erase_req),
    .stall     (dl_go),
    .addr      (er_addr),
    .we        (er_we),
    .busy      (er_busy)
  );

  assign erase_busy   = er_busy;
  assign cpu.cpu_hold = er_busy;

  // ---- RAM port mux ----
  always_comb begin
    mem_req.addr = cpu.cpu_addr;
    mem_req.din  = cpu.cpu_dout;
    mem_req.we   = cpu.cpu_wr & cpu.cpu_clken & (dec_sel == SEL_RAM);
    mem_req.ena  = cpu.cpu_clken;
    if (dl_go) begin
      mem_req.addr = dl_addr[CPU_AW-1:0];
      mem_req.din  = dl_data;
      mem_req.we   = dl_in_ram;
      mem_req.ena  = 1'b1;
    end else if (er_we) begin
      mem_req.addr = er_addr;
      mem_req.din  = FILL_VALUE;
      mem_req.we   = 1'b1;
      mem_req.ena  = 1'b1;
    end
  end

  // Strobes are forced low while reset is held so nothing reaches RAM mid-reset.
  assign mem_addr = mem_req.addr;
  assign mem_din  = mem_req.din;
  assign mem_we   = reset_n & mem_req.we;
  assign mem_ena  = reset_n & mem_req.ena;

  // ---- download range error, cleared by a new session ----
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      dl_active_q  <= 1'b0;
      dl_range_err <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (dl_go && !dl_in_ram)            dl_range_err <= 1'b1;
      else if (dl_active && !dl_active_q) dl_range_err <= 1'b0;
    end
  end

  // ---- registered read select ----
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n)
      sel_q <= SEL_NONE;
    else if (cpu.cpu_rd && cpu.cpu_clken && !er_busy)
      sel_q <= dec_sel;
  end

  always_comb begin
    case (sel_q)
      SEL_RAM:   cpu.bus_dout = ram_dout;
      SEL_BASIC: cpu.bus_dout = basic_dout;
      SEL_WOZ:   cpu.bus_dout = woz_dout;
      default:   cpu.bus_dout = UNMAPPED_VALUE;
    endcase
  end
endmodule

// File: tb/tb_apple1_mem_arbiter.sv
// Bench: small-RAM instance for eraser behaviour, full-map instance for decode,
// ROM protect and downloader checks; reads go through a scoreboard queue.
module tb_apple1_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        dl_active, dl_wr, s_ereq, f_ereq;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;

  apple1_mem_arbiter_if s_if ();
  apple1_mem_arbiter_if f_if ();

  logic        s_busy, s_err, s_we, s_ena;
  logic [15:0] s_addr;
  logic [7:0]  s_din;
  logic        f_busy, f_err, f_we, f_ena;
  logic [15:0] f_addr;
  logic [7:0]  f_din;
  logic [7:0]  f_ram_q = 8'h00, f_basic_q = 8'h00, f_woz_q = 8'h00;

  apple1_mem_arbiter #(.RAM_TOP(16'h0010)) u_small (
    .sys_clock(clk), .reset_n(rst_n), .cpu(s_if),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .erase_req(s_ereq), .erase_busy(s_busy), .dl_range_err(s_err),
    .mem_addr(s_addr), .mem_din(s_din), .mem_we(s_we), .mem_ena(s_ena),
    .ram_dout(8'h11), .basic_dout(8'h22), .woz_dout(8'h33));

  apple1_mem_arbiter #(.ERASE_ON_RESET(1'b0)) u_full (
    .sys_clock(clk), .reset_n(rst_n), .cpu(f_if),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .erase_req(f_ereq), .erase_busy(f_busy), .dl_range_err(f_err),
    .mem_addr(f_addr), .mem_din(f_din), .mem_we(f_we), .mem_ena(f_ena),
    .ram_dout(f_ram_q), .basic_dout(f_basic_q), .woz_dout(f_woz_q));

  // Synchronous memory models for the full instance; ROM content is addr-derived.
  bit [7:0] tram [0:65535];
  always @(posedge clk) if (f_ena) begin
    if (f_we) tram[f_addr] <= f_din;
    f_ram_q   <= tram[f_addr];
    f_basic_q <= f_addr[7:0] ^ 8'h5A;
    f_woz_q   <= f_addr[7:0] ^ 8'hC3;
  end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected read data queued at issue, compared one clock later.
  logic [7:0] exp_q [$];
  logic       f_rd_seen = 1'b0;
  always @(posedge clk) f_rd_seen <= f_if.cpu_rd & f_if.cpu_clken;
  always @(negedge clk) if (f_rd_seen) begin
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_underflow: got read with no expected entry");
    end else chk("rd_data", f_if.bus_dout, exp_q.pop_front());
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr, rd, clken;
    logic [7:0]  din;
    logic        exp_we, exp_ena;
    logic [7:0]  exp_rd;
  } vec_t;
  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic f_idle();
    f_if.cpu_clken = 1'b0; f_if.cpu_rd = 1'b0; f_if.cpu_wr = 1'b0;
  endtask
  task automatic s_idle();
    s_if.cpu_clken = 1'b0; s_if.cpu_rd = 1'b0; s_if.cpu_wr = 1'b0;
    s_if.cpu_addr = 16'h0000; s_if.cpu_dout = 8'h00;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    //          addr      wr    rd    clken din    we    ena   rd data
    tbl[0]  = '{16'h0200, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00};
    tbl[1]  = '{16'h0201, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{16'h0200, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[3]  = '{16'h0201, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{16'hBFFF, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h00};
    tbl[5]  = '{16'hC000, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{16'hBFFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h3C};
    tbl[7]  = '{16'hC000, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{16'hE123, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h00};
    tbl[9]  = '{16'hFF10, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{16'hE123, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h79};
    tbl[11] = '{16'hFF10, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hD3};
    tbl[12] = '{16'hD000, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[13] = '{16'hE000, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h5A};
    tbl[14] = '{16'hEFFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[15] = '{16'hF000, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[16] = '{16'hFEFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[17] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h3C};
    tbl[18] = '{16'h0200, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'h00;
    s_ereq = 1'b0; f_ereq = 1'b0;
    s_idle();
    // CPU strobes active during reset must not reach the RAM
    f_if.cpu_clken = 1'b1; f_if.cpu_wr = 1'b1; f_if.cpu_rd = 1'b0;
    f_if.cpu_addr = 16'h0200; f_if.cpu_dout = 8'hEE;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_hold", s_if.cpu_hold, 1'b0);
    chk("rst_err", s_err, 1'b0);
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_f_we", f_we, 1'b0);
    chk("rst_f_ena", f_ena, 1'b0);
    chk("rst_f_bus", f_if.bus_dout, 8'h00);
    f_idle();

    // ---- erase on reset release, 16 locations ----
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("boot_busy_pre", s_busy, 1'b0);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      chk($sformatf("boot_busy[%0d]", a), s_busy, 1'b1);
      chk($sformatf("boot_hold[%0d]", a), s_if.cpu_hold, 1'b1);
      chk($sformatf("boot_addr[%0d]", a), {s_we, s_din, s_addr}, {1'b1, 8'h00, 16'(a)});
    end
    @(negedge clk);
    chk("done_busy", s_busy, 1'b0);
    chk("done_we", s_we, 1'b0);
    @(negedge clk);
    chk("idle_busy", s_busy, 1'b0);
    chk("full_no_boot_erase", f_busy, 1'b0);

    // ---- CPU decode / write-protect / read latency table ----
    for (int i = 0; i < NV; i++) begin
      tick();
      f_if.cpu_addr  = tbl[i].addr;
      f_if.cpu_wr    = tbl[i].wr;
      f_if.cpu_rd    = tbl[i].rd;
      f_if.cpu_clken = tbl[i].clken;
      f_if.cpu_dout  = tbl[i].din;
      if (tbl[i].rd && tbl[i].clken) exp_q.push_back(tbl[i].exp_rd);
      @(negedge clk);
      chk($sformatf("we[%0d]", i), f_we, tbl[i].exp_we);
      chk($sformatf("ena[%0d]", i), f_ena, tbl[i].exp_ena);
    end
    tick(); f_idle();
    @(negedge clk);
    chk("rd_hold_no_clken", f_if.bus_dout, 8'h3C);

    // ---- downloader range error ----
    tick(); dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h00C000; dl_data = 8'h99;
    @(negedge clk);
    chk("dl_oor_we", f_we, 1'b0);
    chk("dl_oor_ena", f_ena, 1'b1);
    chk("dl_oor_addr", {f_addr, f_din}, {16'hC000, 8'h99});
    tick(); dl_wr = 1'b0;
    @(negedge clk);
    chk("dl_err_set", f_err, 1'b1);
    repeat (2) tick();
    dl_active = 1'b0;
    @(negedge clk);
    chk("dl_err_sticky", f_err, 1'b1);
    tick(); dl_active = 1'b1;
    tick();
    @(negedge clk);
    chk("dl_err_clear", f_err, 1'b0);
    tick(); dl_wr = 1'b1; dl_addr = 25'h000300; dl_data = 8'h42;
    @(negedge clk);
    chk("dl_in_we", {f_we, f_addr, f_din}, {1'b1, 16'h0300, 8'h42});
    tick(); dl_addr = 25'h010005;
    @(negedge clk);
    chk("dl_hi_we", f_we, 1'b0);
    tick(); dl_wr = 1'b0;
    f_if.cpu_addr = 16'h0300; f_if.cpu_rd = 1'b1; f_if.cpu_clken = 1'b1;
    exp_q.push_back(8'h42);
    @(negedge clk);
    chk("dl_hi_err", f_err, 1'b1);
    tick(); f_idle(); dl_active = 1'b0;
    tick();

    // ---- erase_req with simultaneous dl write, then dl write mid-erase ----
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h000017; dl_data = 8'h77; s_ereq = 1'b1;
    @(negedge clk);
    chk("req_dl_wins", {s_we, s_addr, s_din}, {1'b0, 16'h0017, 8'h77});
    chk("req_busy0", s_busy, 1'b0);
    tick(); dl_wr = 1'b0; s_ereq = 1'b0;
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      chk($sformatf("er_addr[%0d]", a), {s_busy, s_addr}, {1'b1, 16'(a)});
      tick();
    end
    dl_wr = 1'b1; dl_addr = 25'h000005; dl_data = 8'h5D;
    @(negedge clk);
    chk("dl_mid_erase", {s_we, s_addr, s_din}, {1'b1, 16'h0005, 8'h5D});
    tick(); dl_wr = 1'b0; s_ereq = 1'b1;
    @(negedge clk);
    chk("er_resume", {s_we, s_addr, s_din}, {1'b1, 16'h0003, 8'h00});
    tick(); s_ereq = 1'b0;
    for (int a = 4; a <= 8; a++) begin
      @(negedge clk);
      chk($sformatf("er_addr[%0d]", a), {s_busy, s_addr}, {1'b1, 16'(a)});
      if (a < 8) tick();
    end
    chk("s_err_pre_rst", s_err, 1'b1);

    // ---- async reset mid-erase ----
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", s_busy, 1'b0);
    chk("ar_hold", s_if.cpu_hold, 1'b0);
    chk("ar_we_ena", {s_we, s_ena}, 2'b00);
    chk("ar_err", s_err, 1'b0);
    chk("ar_f_bus", f_if.bus_dout, 8'h00);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("re_busy_pre", s_busy, 1'b0);
    @(negedge clk);
    chk("re_addr0", {s_busy, s_we, s_addr}, {1'b1, 1'b1, 16'h0000});
    tick(); s_if.cpu_addr = 16'hFF00; s_if.cpu_rd = 1'b1; s_if.cpu_clken = 1'b1;
    @(negedge clk);
    chk("re_addr1_cpu_ignored", {s_we, s_addr}, {1'b1, 16'h0001});
    tick(); s_idle();
    @(negedge clk);
    chk("hold_blocks_sel", s_if.bus_dout, 8'h00);
    chk("re_addr2", s_addr, 16'h0002);
    n = 0;
    while (s_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("erase_remaining_cycles", n, 14);
    tick(); s_if.cpu_addr = 16'hFF00; s_if.cpu_rd = 1'b1; s_if.cpu_clken = 1'b1;
    tick(); s_idle();
    @(negedge clk);
    chk("post_erase_woz_rd", s_if.bus_dout, 8'h33);
    chk("post_erase_hold", s_if.cpu_hold, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
